// File: rtl/apu_shared_unit_arb_pkg.sv
// apu_shared_unit_arb_pkg: cluster constants and per-unit parameter lookup for shared APU units
package apu_shared_unit_arb_pkg;
  localparam int C_MAX_OUTSTANDING = 2;
  typedef enum logic [2:0] {U_ADDSUB, U_MULT, U_MAC, U_CAST, U_DIV, U_SQRT, U_IMUL, U_DSP} unit_e;
  function automatic int unit_pipe_regs(unit_e u);
    return (u == U_DIV || u == U_SQRT) ? 4 : (u == U_MAC || u == U_IMUL) ? 2 : 1;
  endfunction
  function automatic int unit_wop(unit_e u);
    return (u == U_CAST || u == U_IMUL) ? 2 : 1;
  endfunction
  function automatic int unit_ndsflags(unit_e u);
    return (u == U_IMUL || u == U_DSP) ? 1 : 3;
  endfunction
  function automatic int unit_nusflags(unit_e u);
    return (u == U_IMUL || u == U_DSP) ? 1 : 5;
  endfunction
endpackage

// File: rtl/apu_rr_arbiter.sv
// apu_rr_arbiter: round-robin pick among eligible requesters starting at a pointer
module apu_rr_arbiter import apu_shared_unit_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] w_j;
  // walk offsets from the far end so the candidate nearest the pointer wins last
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_elig[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        o_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apu_shared_unit_arb.sv
// apu_shared_unit_arb: N-core round-robin front end for one shared fixed-latency APU unit
module apu_shared_unit_arb import apu_shared_unit_arb_pkg::*; #(
  parameter int NCORES    = 4,
  parameter int WIDTH     = 32,
  parameter int NARGS     = 3,
  parameter int WOP       = 1,
  parameter int NDSFLAGS  = 3,
  parameter int NUSFLAGS  = 5,
  parameter int PIPE_REGS = 1,
  parameter int MAX_OUT   = C_MAX_OUTSTANDING
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NCORES-1:0]                        core_req_i,
  output logic [NCORES-1:0]                        core_gnt_o,
  input  logic [NCORES-1:0][NARGS-1:0][WIDTH-1:0]  core_operands_i,
  input  logic [NCORES-1:0][WOP-1:0]               core_op_i,
  input  logic [NCORES-1:0][NDSFLAGS-1:0]          core_flags_i,
  output logic [NCORES-1:0]                        core_rvalid_o,
  output logic [WIDTH-1:0]                         core_result_o,
  output logic [NUSFLAGS-1:0]                      core_flags_o,
  output logic                                     unit_valid_o,
  output logic [NARGS-1:0][WIDTH-1:0]              unit_operands_o,
  output logic [WOP-1:0]                           unit_op_o,
  output logic [NDSFLAGS-1:0]                      unit_flags_o,
  input  logic                                     unit_rvalid_i,
  input  logic [WIDTH-1:0]                         unit_result_i,
  input  logic [NUSFLAGS-1:0]                      unit_flags_i,
  output logic                                     err_o
);
  localparam int IW = $clog2(NCORES);
  localparam int CW = $clog2(MAX_OUT + 1);
  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;
  tag_t              r_tag [PIPE_REGS];
  logic [CW-1:0]     r_cnt [NCORES];
  logic [IW-1:0]     r_ptr;
  logic              r_err;
  logic [NCORES-1:0] w_elig;
  logic [NCORES-1:0] w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  tag_t              w_last;
  assign w_last = r_tag[PIPE_REGS-1];
  // a core may issue only while below its cap; reset silences all grants at once
  always_comb begin
    w_elig = '0;
    for (int c = 0; c < NCORES; c++) w_elig[c] = core_req_i[c] && !rst_i && r_cnt[c] < CW'(MAX_OUT);
  end
  apu_rr_arbiter #(.N(NCORES), .IW(IW)) u_arb (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );
  assign core_gnt_o      = w_gnt;
  assign unit_valid_o    = w_any;
  assign unit_operands_o = core_operands_i[w_idx];
  assign unit_op_o       = core_op_i[w_idx];
  assign unit_flags_o    = core_flags_i[w_idx];
  assign core_result_o   = unit_result_i;
  assign core_flags_o    = unit_flags_i;
  assign core_rvalid_o   = (unit_rvalid_i && w_last.valid) ? NCORES'(1) << w_last.id : '0;
  assign err_o           = r_err;
  // core-id tags travel alongside the unit pipeline so each result finds its issuer
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int i = 0; i < PIPE_REGS; i++) r_tag[i] <= '0;
    else begin
      r_tag[0] <= '{valid: w_any, id: w_idx};
      for (int i = 1; i < PIPE_REGS; i++) r_tag[i] <= r_tag[i-1];
    end
  // outstanding counters, rotating pointer and sticky error on tag/result disagreement
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int c = 0; c < NCORES; c++) r_cnt[c] <= '0;
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      for (int c = 0; c < NCORES; c++)
        r_cnt[c] <= r_cnt[c] + CW'(w_gnt[c]) - CW'(w_last.valid && w_last.id == IW'(c));
      r_ptr <= w_any ? ((w_idx == IW'(NCORES - 1)) ? '0 : w_idx + 1'b1) : r_ptr;
      r_err <= r_err | (unit_rvalid_i != w_last.valid);
    end
endmodule

// File: tb/tb_apu_shared_unit_arb.sv
// tb_apu_shared_unit_arb: directed stimulus checked against a queue-based reference model
module tb_apu_shared_unit_arb;
  localparam int N = 4, W = 32, A = 3, P = 4, M = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0]             req, req1, gnt, rv, gnt1, rv1;
  logic [N-1:0][A-1:0][W-1:0] opnd;
  logic [N-1:0][0:0]        op;
  logic [N-1:0][2:0]        dsf;
  logic [W-1:0]             res, res1, ures;
  logic [4:0]               fl, fl1, ufl;
  logic                     uv, uv1, err, err1, urv, sh1, spur, drop;
  logic [A-1:0][W-1:0]      uop, uop1;
  logic [0:0]               uopc, uopc1;
  logic [2:0]               ufo, ufo1;
  logic [P-1:0]             ush;
  int checks = 0, errors = 0;

  apu_shared_unit_arb #(.NCORES(N), .WIDTH(W), .NARGS(A), .WOP(1), .NDSFLAGS(3), .NUSFLAGS(5),
    .PIPE_REGS(P), .MAX_OUT(M)) dut (
    .clk_i(clk), .rst_i(rst), .core_req_i(req), .core_gnt_o(gnt), .core_operands_i(opnd),
    .core_op_i(op), .core_flags_i(dsf), .core_rvalid_o(rv), .core_result_o(res), .core_flags_o(fl),
    .unit_valid_o(uv), .unit_operands_o(uop), .unit_op_o(uopc), .unit_flags_o(ufo),
    .unit_rvalid_i(urv), .unit_result_i(ures), .unit_flags_i(ufl), .err_o(err));

  apu_shared_unit_arb #(.NCORES(N), .WIDTH(W), .NARGS(A), .WOP(1), .NDSFLAGS(3), .NUSFLAGS(5),
    .PIPE_REGS(1), .MAX_OUT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .core_req_i(req1), .core_gnt_o(gnt1), .core_operands_i(opnd),
    .core_op_i(op), .core_flags_i(dsf), .core_rvalid_o(rv1), .core_result_o(res1), .core_flags_o(fl1),
    .unit_valid_o(uv1), .unit_operands_o(uop1), .unit_op_o(uopc1), .unit_flags_o(ufo1),
    .unit_rvalid_i(sh1), .unit_result_i(ures), .unit_flags_i(ufl), .err_o(err1));

  // the shared unit itself: fixed latency echo of issue strobes, with fault injection
  assign urv = (ush[P-1] & ~drop) | spur;
  always @(posedge clk or posedge rst)
    if (rst) begin ush <= '0; sh1 <= 1'b0; ures <= 32'h1234_0000; ufl <= '0; end
    else begin ush <= {ush[P-2:0], uv}; sh1 <= uv1; ures <= ures + 32'h0101_0101; ufl <= ufl + 5'd3; end

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  typedef struct { int core; int due; } op_t;
  op_t q[$];
  int  mcnt[N];
  int  mptr = 0, mcyc = 0, g;
  bit  merr = 0, lv;
  logic [N-1:0] eg, er;
  // reference: grants from counts and pointer, retirements from issue time + latency
  always @(negedge clk) begin
    if (rst) begin
      q.delete(); mcnt = '{default: 0}; mptr = 0; mcyc = 0; merr = 0;
      chk("rst_gnt", gnt, 0); chk("rst_rv", rv, 0); chk("rst_uv", uv, 0); chk("rst_err", err, 0);
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(mptr + k) % N] && mcnt[(mptr + k) % N] < M) g = (mptr + k) % N;
      lv = q.size() > 0 && q[0].due == mcyc;
      eg = (g < 0) ? '0 : N'(1) << g;
      er = (lv && urv) ? N'(1) << q[0].core : '0;
      chk("gnt", gnt, eg);
      chk("uv", uv, g >= 0);
      chk("rvalid", rv, er);
      chk("err", err, merr);
      chk("result", {fl, res}, {ufl, ures});
      if (g >= 0) chk("unit_mux", {ufo, uopc, uop}, {dsf[g], op[g], opnd[g]});
      merr |= (lv != urv);
      if (lv) begin mcnt[q[0].core]--; void'(q.pop_front()); end
      if (g >= 0) begin mcnt[g]++; q.push_back('{g, mcyc + P}); mptr = (g + 1) % N; end
      mcyc++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [7:0] gvec;
  initial begin
    req = '0; req1 = '0; spur = 0; drop = 0;
    for (int c = 0; c < N; c++) begin
      for (int a = 0; a < A; a++) opnd[c][a] = 32'h3f80_0000 ^ W'(((c ^ 2) << 8) | (a << 4));
      op[c] = 1'(c & 1);
      dsf[c] = 3'(c + 1);
    end
    repeat (2) @(posedge clk); #1 rst = 0;
    // latency-1 instance, single request from core 2
    req1 = 4'b0100;
    @(negedge clk); chk("p1_gnt", gnt1, 4'b0100); chk("p1_uv", uv1, 1); chk("p1_opnd", uop1[0], 32'h3f80_0000);
    step(); req1 = '0;
    @(negedge clk); chk("p1_rv", rv1, 4'b0100); chk("p1_gnt_idle", gnt1, 0);
    step(); req1 = 4'b0100;
    @(negedge clk); chk("p1_regrant", gnt1, 4'b0100); chk("p1_rv_idle", rv1, 0);
    step(); req1 = '0;
    @(negedge clk); chk("p1_rv2", rv1, 4'b0100);
    step();
    // all cores request continuously: strict rotation from core 0
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("rotate", gnt, N'(1) << (i % 4));
      step();
    end
    req = '0; repeat (6) step();
    // single core saturates its cap; pattern identical for core 1 and core 0
    for (int c = 1; c >= 0; c--) begin
      req = N'(1) << c;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); gvec[i] = gnt[c];
        step();
      end
      chk("cap_pattern", gvec, 8'b0110_0011);
      req = '0; repeat (6) step();
    end
    // spurious result with empty pipeline
    spur = 1;
    @(negedge clk); chk("spur_rv", rv, 0);
    step(); spur = 0;
    repeat (3) begin @(negedge clk); chk("spur_err", err, 1); step(); end
    rst = 1; repeat (2) step(); rst = 0;
    @(negedge clk); chk("err_cleared", err, 0);
    step();
    // missing result: slot must still free up
    req = 4'b1000;
    @(negedge clk); chk("drop_gnt", gnt, 4'b1000);
    step(); req = '0;
    step(); step(); step(); drop = 1;
    @(negedge clk); chk("drop_rv", rv, 0);
    step(); drop = 0;
    @(negedge clk); chk("drop_err", err, 1);
    req = 4'b1000; step(); step(); step(); req = '0;
    repeat (6) step();
    rst = 1; repeat (2) step(); rst = 0;
    // reset with three ops in flight
    req = 4'b0111;
    repeat (3) step();
    req = 4'b1100; rst = 1;
    #1 chk("rst_now", {gnt, rv, uv, err}, 0);
    repeat (2) step(); rst = 0;
    @(negedge clk); chk("post_rst_gnt", gnt, 4'b0100);
    step(); req = '0;
    repeat (7) step();
    chk("p1_err", err1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
